// File: rtl/led_serial_receiver.sv
// Deserializer for the serial LED stream: recovers frame alignment from the
// active-low latch pulse, undoes the half swap and strobes each good word.
module led_serial_receiver #(
  parameter int WIDTH       = 16,
  parameter bit SWAP_HALVES = 1'b1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sdi,
  input  logic                 latch_n,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-2:0]     shreg_q, shreg_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [WIDTH-1:0]     rx;
  logic [WIDTH-1:0]     rx_word;
  logic                 last_bit;

  // The current sample completes the word, so rx already holds all WIDTH bits.
  assign rx       = {shreg_q, sdi};
  assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));

  generate
    if (SWAP_HALVES) begin : g_swap
      assign rx_word = {rx[WIDTH/2-1:0], rx[WIDTH-1:WIDTH/2]};
    end else begin : g_noswap
      assign rx_word = rx;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    shreg_d      = rx[WIDTH-2:0];
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      ST_HUNT: begin
        // The first latch seen only aligns; the partial frame is dropped.
        if (!latch_n) begin
          state_d   = ST_LOCKED;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (latch_n) begin
          if (last_bit) begin
            frame_err_d = 1'b1;
            state_d     = ST_HUNT;
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          // A latch always realigns; only a full-length frame yields data.
          bit_cnt_d = '0;
          shreg_d   = '0;
          if (last_bit) begin
            data_out_d   = rx_word;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Clear takes priority over an error arriving on the same edge.
    err_count_d = err_count_q;
    if (err_clr) begin
      err_count_d = '0;
    end else if (frame_err_d && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign locked     = (state_q == ST_LOCKED);
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_led_serial_receiver.sv
// Directed bench for led_serial_receiver: table of full frames followed by
// hand-written short/long frame, error saturation and mid-frame reset cases.
module tb_led_serial_receiver;

  logic        clk;
  logic        rst_n;
  logic        sdi;
  logic        latch_n;
  logic        err_clr;
  logic [15:0] data_out;
  logic        data_valid;
  logic        frame_err;
  logic        locked;
  logic [7:0]  err_count;
  logic [15:0] e2_data_out;
  logic        e2_data_valid;
  logic        e2_frame_err;
  logic        e2_locked;
  logic [1:0]  e2_err_count;

  int checks_total;
  int checks_passed;
  int nv;
  int ne;

  led_serial_receiver dut (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .latch_n(latch_n), .err_clr(err_clr),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
    .locked(locked), .err_count(err_count)
  );

  led_serial_receiver #(.ERR_CNT_W(2)) dut_e2 (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .latch_n(latch_n), .err_clr(err_clr),
    .data_out(e2_data_out), .data_valid(e2_data_valid), .frame_err(e2_frame_err),
    .locked(e2_locked), .err_count(e2_err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] src;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_locked;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drive one sample on the falling edge; look at outputs just after the rising edge.
  task automatic send_bit(input logic b, input logic l);
    @(negedge clk);
    sdi     = b;
    latch_n = l;
    @(posedge clk);
    #1;
    if (data_valid) nv++;
    if (frame_err) ne++;
    if (data_valid && frame_err) chk("valid_err_exclusive", 1, 0);
  endtask

  task automatic send_frame(input logic [15:0] src, input logic with_latch);
    logic [15:0] tx;
    tx = {src[7:0], src[15:8]};
    nv = 0;
    ne = 0;
    for (int i = 15; i >= 0; i--) send_bit(tx[i], (i == 0 && with_latch) ? 1'b0 : 1'b1);
  endtask

  task automatic send_short(input int bits_before_latch);
    nv = 0;
    ne = 0;
    for (int i = 0; i < bits_before_latch; i++) send_bit(i[0], 1'b1);
    send_bit(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    sdi     = 1'b0;
    latch_n = 1'b1;
    err_clr = 1'b0;
    rst_n   = 1'b0;

    vecs[0] = '{src: 16'hA55A, exp_valid: 1'b0, exp_data: 16'h0000, exp_locked: 1'b1};
    vecs[1] = '{src: 16'hA55A, exp_valid: 1'b1, exp_data: 16'hA55A, exp_locked: 1'b1};
    vecs[2] = '{src: 16'h1234, exp_valid: 1'b1, exp_data: 16'h1234, exp_locked: 1'b1};
    vecs[3] = '{src: 16'hFFFF, exp_valid: 1'b1, exp_data: 16'hFFFF, exp_locked: 1'b1};
    vecs[4] = '{src: 16'h0F3C, exp_valid: 1'b1, exp_data: 16'h0F3C, exp_locked: 1'b1};

    repeat (3) @(negedge clk);
    #1;
    chk("reset_data_out", data_out, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_locked", locked, 0);
    chk("reset_err_count", err_count, 0);
    rst_n = 1'b1;

    // Back-to-back frames: exactly one valid per frame, on its last bit.
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].src, 1'b1);
      chk($sformatf("vec%0d_valid_last", v), data_valid, vecs[v].exp_valid);
      chk($sformatf("vec%0d_valid_count", v), nv, vecs[v].exp_valid);
      chk($sformatf("vec%0d_data", v), data_out, vecs[v].exp_data);
      chk($sformatf("vec%0d_locked", v), locked, vecs[v].exp_locked);
      chk($sformatf("vec%0d_err_count", v), err_count, 0);
    end

    // Short frame: latch on the 10th bit.
    send_short(9);
    chk("short_frame_err", frame_err, 1);
    chk("short_valid_count", nv, 0);
    chk("short_err_count", err_count, 1);
    chk("short_locked", locked, 1);
    chk("short_data_hold", data_out, 16'h0F3C);
    send_frame(16'h00FF, 1'b1);
    chk("after_short_valid", data_valid, 1);
    chk("after_short_data", data_out, 16'h00FF);
    chk("after_short_err_pulses", ne, 0);

    // Long frame: latch missing, error on the last bit of the frame.
    send_frame(16'hBEEF, 1'b0);
    chk("long_frame_err", frame_err, 1);
    chk("long_locked", locked, 0);
    chk("long_err_count", err_count, 2);
    chk("long_valid_count", nv, 0);
    send_frame(16'hBEEF, 1'b1);
    chk("relock_valid_count", nv, 0);
    chk("relock_locked", locked, 1);
    chk("relock_data_hold", data_out, 16'h00FF);
    send_frame(16'hC0DE, 1'b1);
    chk("relock_frame_valid", data_valid, 1);
    chk("relock_frame_data", data_out, 16'hC0DE);

    // Saturation on the 2-bit counter, then clear colliding with an error.
    do_reset();
    send_frame(16'h0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      send_short(3);
      chk($sformatf("sat_short%0d_err", k), e2_frame_err, 1);
    end
    chk("sat_e2_count", e2_err_count, 3);
    chk("sat_main_count", err_count, 5);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
    err_clr = 1'b1;
    send_bit(1'b1, 1'b0);
    err_clr = 1'b0;
    chk("clr_e2_frame_err", e2_frame_err, 1);
    chk("clr_e2_count", e2_err_count, 0);
    chk("clr_main_count", err_count, 0);
    send_frame(16'h5A5A, 1'b1);
    chk("post_clr_valid", data_valid, 1);
    chk("post_clr_data", data_out, 16'h5A5A);

    // Reset asserted 7 bits into a locked frame.
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1);
    @(negedge clk);
    sdi = 1'b1;
    latch_n = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_data_out", data_out, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_valid", data_valid, 0);
    repeat (2) @(negedge clk);
    latch_n = 1'b1;
    rst_n = 1'b1;
    send_frame(16'h1234, 1'b1);
    chk("midrst_relock_valid_count", nv, 0);
    chk("midrst_relock_locked", locked, 1);
    chk("midrst_relock_data", data_out, 0);
    send_frame(16'h1234, 1'b1);
    chk("midrst_frame_valid", data_valid, 1);
    chk("midrst_frame_data", data_out, 16'h1234);
    send_bit(1'b0, 1'b1);
    chk("valid_single_cycle", data_valid, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
